regfile_mp: RTL and testbench

Parametrised multi-port integer register file with a per-register busy scoreboard and optional same-cycle write-to-read forwarding. Generalises the single-write, dual-read core register file to configurable depth, width and port counts. Register 0 is hardwired to zero. Sits between decode (read/reserve) and writeback (write/release) and feeds hazard detection through the busy flags.

---
 rtl/regfile_mp.sv | 98 +++++++++
 tb/tb_regfile_mp.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard; x0 reads as zero.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int REG_COUNT  = 32,
    parameter int ADDR_WIDTH = $clog2(REG_COUNT),
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]  raddr_i,
    output logic [NUM_READ*DATA_WIDTH-1:0]  rdata_o,
    output logic [NUM_READ-1:0]             rbusy_o,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0] waddr_i,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0] wdata_i,
    input  logic [NUM_WRITE-1:0]            we_i,
    input  logic                            rsv_valid_i,
    input  logic [ADDR_WIDTH-1:0]           rsv_addr_i,
    output logic                            rsv_ready_o
);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic [REG_COUNT-1:0]  busy;

    logic [ADDR_WIDTH-1:0] waddr [NUM_WRITE];
    logic [DATA_WIDTH-1:0] wdata [NUM_WRITE];
    logic [NUM_WRITE-1:0]  wr_act;
    logic [REG_COUNT-1:0]  release_vec;
    logic                  rsv_accept;

    // A write is only live outside reset and never targets x0.
    for (genvar j = 0; j < NUM_WRITE; j++) begin : g_wr
        assign waddr[j]  = waddr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata[j]  = wdata_i[j*DATA_WIDTH +: DATA_WIDTH];
        assign wr_act[j] = we_i[j] && !rst && (waddr[j] != '0);
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        release_vec = '0;
        for (int j = 0; j < NUM_WRITE; j++) begin
            if (wr_act[j]) release_vec[waddr[j]] = 1'b1;
        end
    end

    assign rsv_ready_o = (rsv_addr_i == '0) || !busy[rsv_addr_i] || release_vec[rsv_addr_i];
    assign rsv_accept  = rsv_valid_i && rsv_ready_o && (rsv_addr_i != '0);

    // NOTE: the storage array is reset because cleared registers are architecturally visible;
    // regs[0] is never written, so it holds its reset zero forever.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            // NOTE: non-blocking updates issued later win, giving higher write ports
            // priority and letting a same-cycle reserve override the release.
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (wr_act[j]) begin
                    regs[waddr[j]] <= wdata[j];
                    busy[waddr[j]] <= 1'b0;
                end
            end
            if (rsv_accept) busy[rsv_addr_i] <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd;
        logic                  rb;

        assign ra = raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rd = regs[ra];
            rb = busy[ra];
`ifdef REGFILE_BYPASS_EN
            // Ascending scan so the highest matching write port is the one forwarded.
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (wr_act[j] && (waddr[j] == ra)) begin
                    rd = wdata[j];
                    rb = rsv_accept && (rsv_addr_i == ra);
                end
            end
`endif
            if (ra == '0) begin
                rd = '0;
                rb = 1'b0;
            end
        end

        assign rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = rd;
        assign rbusy_o[k]                          = rb;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (2 read, 2 write ports): stimulus pushes expected
// outputs computed from an array model; a negedge monitor pops and compares.
module tb_regfile_mp;

    localparam int RC = 32;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int NW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR*AW-1:0]  raddr_i = '0;
    logic [NR*DW-1:0]  rdata_o;
    logic [NR-1:0]     rbusy_o;
    logic [NW*AW-1:0]  waddr_i = '0;
    logic [NW*DW-1:0]  wdata_i = '0;
    logic [NW-1:0]     we_i = '0;
    logic              rsv_valid_i = 1'b0;
    logic [AW-1:0]     rsv_addr_i = '0;
    logic              rsv_ready_o;

    regfile_mp #(
        .REG_COUNT (RC),
        .DATA_WIDTH(DW),
        .NUM_READ  (NR),
        .NUM_WRITE (NW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .raddr_i    (raddr_i),
        .rdata_o    (rdata_o),
        .rbusy_o    (rbusy_o),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .we_i       (we_i),
        .rsv_valid_i(rsv_valid_i),
        .rsv_addr_i (rsv_addr_i),
        .rsv_ready_o(rsv_ready_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0][DW-1:0] data;
        logic [NR-1:0]         busy;
        logic                  ready;
        string                 tag;
    } exp_t;

    exp_t q[$];

    // Reference model: architectural contents and busy flags.
    logic [DW-1:0] m_reg  [RC];
    bit            m_busy [RC];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic step(input bit r, input int ra0, input int ra1, input bit [1:0] we,
                        input int wa0, input logic [DW-1:0] wd0,
                        input int wa1, input logic [DW-1:0] wd1,
                        input bit rv, input int rva, input bit chk, input string tag);
        exp_t          e;
        int            ra [NR];
        int            wa [NW];
        logic [DW-1:0] wd [NW];
        bit            ready;
        bit            acc;
        ra[0] = ra0; ra[1] = ra1;
        wa[0] = wa0; wa[1] = wa1;
        wd[0] = wd0; wd[1] = wd1;

        @(posedge clk); #1;
        rst         = r;
        raddr_i     = {AW'(ra1), AW'(ra0)};
        we_i        = we;
        waddr_i     = {AW'(wa1), AW'(wa0)};
        wdata_i     = {wd1, wd0};
        rsv_valid_i = rv;
        rsv_addr_i  = AW'(rva);

        ready = (rva == 0) || !m_busy[rva];
        for (int j = 0; j < NW; j++)
            if (!r && we[j] && wa[j] != 0 && wa[j] == rva) ready = 1'b1;
        acc = rv && ready && (rva != 0) && !r;

        for (int k = 0; k < NR; k++) begin
            e.data[k] = (ra[k] == 0) ? '0 : m_reg[ra[k]];
            e.busy[k] = (ra[k] == 0) ? 1'b0 : m_busy[ra[k]];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NW; j++) begin
                if (!r && we[j] && wa[j] != 0 && wa[j] == ra[k]) begin
                    e.data[k] = wd[j];
                    e.busy[k] = acc && (rva == ra[k]);
                end
            end
`endif
        end
        e.ready = ready;
        e.tag   = tag;
        if (chk) q.push_back(e);

        // Model state after the coming edge.
        if (r) begin
            for (int i = 0; i < RC; i++) begin
                m_reg[i]  = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (we[j] && wa[j] != 0) begin
                    m_reg[wa[j]]  = wd[j];
                    m_busy[wa[j]] = 1'b0;
                end
            end
            if (acc) m_busy[rva] = 1'b1;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            for (int k = 0; k < NR; k++) begin
                check($sformatf("%s rdata%0d", e.tag, k), 64'(rdata_o[k*DW +: DW]), 64'(e.data[k]));
                check($sformatf("%s rbusy%0d", e.tag, k), 64'(rbusy_o[k]), 64'(e.busy[k]));
            end
            check($sformatf("%s ready", e.tag), 64'(rsv_ready_o), 64'(e.ready));
        end
    end

    initial begin
        for (int i = 0; i < RC; i++) begin
            m_reg[i]  = 'x;
            m_busy[i] = 1'b0;
        end

        step(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, "rst_a");
        step(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, "rst_b");
        for (int i = 0; i < 16; i++)
            step(0, i, i + 16, 2'b00, 0, 0, 0, 0, 0, i, 1, "rst_read");

        step(0, 5, 0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 1, "wr_x5");
        step(0, 5, 5, 2'b00, 0, 0, 0, 0, 0, 0, 1, "rd_x5");
        step(0, 0, 0, 2'b01, 0, 32'h1234, 0, 0, 0, 0, 1, "wr_x0");
        step(0, 0, 5, 2'b00, 0, 0, 0, 0, 0, 0, 1, "rd_x0");

        step(0, 7, 0, 2'b00, 0, 0, 0, 0, 1, 7, 1, "rsv7_a");
        step(0, 7, 0, 2'b00, 0, 0, 0, 0, 1, 7, 1, "rsv7_b");
        step(0, 7, 7, 2'b01, 7, 32'h55, 0, 0, 1, 7, 1, "wr_rsv7");
        step(0, 7, 0, 2'b00, 0, 0, 0, 0, 1, 7, 1, "rd_x7");

        step(0, 0, 3, 2'b01, 3, 32'hA5A5A5A5, 0, 0, 0, 0, 1, "fwd_x3");
        step(0, 0, 3, 2'b00, 0, 0, 0, 0, 0, 0, 1, "rd_x3");

        step(0, 9, 0, 2'b11, 9, 32'h1, 9, 32'h2, 0, 0, 1, "wr2_x9");
        step(0, 9, 9, 2'b00, 0, 0, 0, 0, 0, 0, 1, "rd_x9");

        step(0, 4, 6, 2'b00, 0, 0, 0, 0, 1, 4, 1, "rsv_x4");
        step(0, 4, 6, 2'b01, 6, 32'h66, 0, 0, 0, 0, 1, "wr_x6");
        step(1, 4, 6, 2'b10, 0, 0, 8, 32'h88, 1, 8, 1, "mid_rst");
        step(0, 4, 6, 2'b00, 0, 0, 0, 0, 0, 8, 1, "post_rst");
        step(0, 8, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, "post_rst8");

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 49) == 0),
                 $urandom_range(0, 15), $urandom_range(0, 15),
                 2'($urandom),
                 $urandom_range(0, 15), $urandom,
                 $urandom_range(0, 15), $urandom,
                 1'($urandom), $urandom_range(0, 15), 1, "rand");
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
